// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- execute stage of the 16-bit pipeline.
//
// Computes the ALU result from the decoded operands and holds the EX/MEM
// pipeline register that feeds the memory stage. Single-cycle operations
// have a latency of one edge. MUL is an iterative shift-add multiplier.
// Its first iteration runs on the accept edge and one more runs on each
// busy edge, so the product lands MUL_CYCLES edges after acceptance.
//
// Optional build macro: EX_FWD_EN
//   Adds SrcA/UseA/SrcB/UseB and forwards the current EX/MEM ALU result
//   into an operand at acceptance when the register numbers match.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   in_valid, flush         instruction present / squash
//   AluOp, OperandA/B       operation select and operands
//   Immediate, PC,          fields carried through to the memory stage
//   StoreData, MemSignals,
//   RegWr, Rd
//   busy                    stage is multiplying; upstream must hold
//   out_valid .. Negative   EX/MEM pipeline register outputs
// ---------------------------------------------------------------------------
module ex_stage #(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             flush,
  input  logic [2:0]       AluOp,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic [WIDTH-1:0] Immediate,
  input  logic [WIDTH-1:0] PC,
  input  logic [WIDTH-1:0] StoreData,
  input  logic [6:0]       MemSignals,
  input  logic             RegWr,
  input  logic [2:0]       Rd,
`ifdef EX_FWD_EN
  input  logic [2:0]       SrcA,
  input  logic             UseA,
  input  logic [2:0]       SrcB,
  input  logic             UseB,
`endif
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] AluResult,
  output logic [WIDTH-1:0] Immediate2,
  output logic [WIDTH-1:0] PC2,
  output logic [WIDTH-1:0] DataMemory,
  output logic [6:0]       signals,
  output logic             RegWr2,
  output logic [2:0]       Rd2,
  output logic             Zero,
  output logic             Negative
);

  localparam int CNT_W = $clog2(MUL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SLL  = 3'b100;
  localparam logic [2:0] OP_SRL  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

  state_t state_r, state_nx_s;

  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] mcand_r, mplier_r, acc_r;
  logic [WIDTH-1:0] imm_l_r, pc_l_r, sd_l_r;
  logic [6:0]       sig_l_r;
  logic             rw_l_r;
  logic [2:0]       rd_l_r;

  logic [WIDTH-1:0] op_a_s, op_b_s, alu_s, partial_s, acc_step_s;
  logic             accept_s, accept_mul_s, load_single_s, load_mul_s;

  logic             valid_nx_s, rw_nx_s, zero_nx_s, neg_nx_s;
  logic [WIDTH-1:0] res_nx_s, imm_nx_s, pc_nx_s, sd_nx_s;
  logic [6:0]       sig_nx_s;
  logic [2:0]       rd_nx_s;

`ifdef EX_FWD_EN
  logic fwd_ok_s;

  // Operand forwarding from the EX/MEM register when it holds an ALU writeback.
  always_comb begin
    fwd_ok_s = out_valid & RegWr2 & (signals[1:0] == 2'b01);
    if (UseA && fwd_ok_s && (Rd2 == SrcA)) begin
      op_a_s = AluResult;
    end else begin
      op_a_s = OperandA;
    end
    if (UseB && fwd_ok_s && (Rd2 == SrcB)) begin
      op_b_s = AluResult;
    end else begin
      op_b_s = OperandB;
    end
  end
`else
  // Operands are used as given; hazards are resolved upstream.
  always_comb begin
    op_a_s = OperandA;
    op_b_s = OperandB;
  end
`endif

  // Single-cycle ALU.
  always_comb begin
    alu_s = '0;
    case (AluOp)
      OP_AND:  alu_s = op_a_s & op_b_s;
      OP_ADD:  alu_s = op_a_s + op_b_s;
      OP_SUB:  alu_s = op_a_s - op_b_s;
      OP_OR:   alu_s = op_a_s | op_b_s;
      OP_SLL:  alu_s = op_a_s << op_b_s[3:0];
      OP_SRL:  alu_s = op_a_s >> op_b_s[3:0];
      OP_PASS: alu_s = op_b_s;
      default: alu_s = '0;  // MUL goes through the iterative path
    endcase
  end

  // Handshake decode and one shift-add iteration for the busy state.
  always_comb begin
    busy          = (state_r == MUL_BUSY);
    accept_s      = in_valid & ~flush & (state_r == IDLE);
    accept_mul_s  = accept_s & (AluOp == OP_MUL);
    load_single_s = accept_s & (AluOp != OP_MUL);
    load_mul_s    = (state_r == MUL_BUSY) & ~flush & (cnt_r == CNT_LAST);
    partial_s     = mplier_r[0] ? mcand_r : '0;
    acc_step_s    = acc_r + partial_s;
  end

  // FSM next state; flush aborts a multiply even on its completion edge.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_mul_s) begin
          state_nx_s = MUL_BUSY;
        end else begin
          state_nx_s = IDLE;
        end
      end
      MUL_BUSY: begin
        if (flush || (cnt_r == CNT_LAST)) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = MUL_BUSY;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Next EX/MEM contents: single-cycle result, multiply result, or bubble.
  always_comb begin
    valid_nx_s = 1'b0;
    res_nx_s   = '0;
    imm_nx_s   = '0;
    pc_nx_s    = '0;
    sd_nx_s    = '0;
    sig_nx_s   = 7'd0;
    rw_nx_s    = 1'b0;
    rd_nx_s    = 3'd0;
    zero_nx_s  = 1'b0;
    neg_nx_s   = 1'b0;
    if (load_single_s) begin
      valid_nx_s = 1'b1;
      res_nx_s   = alu_s;
      imm_nx_s   = Immediate;
      pc_nx_s    = PC;
      sd_nx_s    = StoreData;
      sig_nx_s   = MemSignals;
      rw_nx_s    = RegWr;
      rd_nx_s    = Rd;
      zero_nx_s  = (alu_s == '0);
      neg_nx_s   = alu_s[WIDTH-1];
    end else if (load_mul_s) begin
      valid_nx_s = 1'b1;
      res_nx_s   = acc_step_s;
      imm_nx_s   = imm_l_r;
      pc_nx_s    = pc_l_r;
      sd_nx_s    = sd_l_r;
      sig_nx_s   = sig_l_r;
      rw_nx_s    = rw_l_r;
      rd_nx_s    = rd_l_r;
      zero_nx_s  = (acc_step_s == '0);
      neg_nx_s   = acc_step_s[WIDTH-1];
    end else begin
      valid_nx_s = 1'b0;  // bubble: everything stays zero
    end
  end

  // EX/MEM pipeline register and FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      out_valid  <= 1'b0;
      AluResult  <= '0;
      Immediate2 <= '0;
      PC2        <= '0;
      DataMemory <= '0;
      signals    <= 7'd0;
      RegWr2     <= 1'b0;
      Rd2        <= 3'd0;
      Zero       <= 1'b0;
      Negative   <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      out_valid  <= valid_nx_s;
      AluResult  <= res_nx_s;
      Immediate2 <= imm_nx_s;
      PC2        <= pc_nx_s;
      DataMemory <= sd_nx_s;
      signals    <= sig_nx_s;
      RegWr2     <= rw_nx_s;
      Rd2        <= rd_nx_s;
      Zero       <= zero_nx_s;
      Negative   <= neg_nx_s;
    end
  end

  // Multiplier datapath and latched instruction fields.
  // Iteration 0 runs on the accept edge, so the counter starts at 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
      acc_r    <= '0;
      imm_l_r  <= '0;
      pc_l_r   <= '0;
      sd_l_r   <= '0;
      sig_l_r  <= 7'd0;
      rw_l_r   <= 1'b0;
      rd_l_r   <= 3'd0;
    end else if (accept_mul_s) begin
      cnt_r    <= CNT_W'(1);
      acc_r    <= op_b_s[0] ? op_a_s : '0;
      mcand_r  <= op_a_s << 1;
      mplier_r <= op_b_s >> 1;
      imm_l_r  <= Immediate;
      pc_l_r   <= PC;
      sd_l_r   <= StoreData;
      sig_l_r  <= MemSignals;
      rw_l_r   <= RegWr;
      rd_l_r   <= Rd;
    end else if (state_r == MUL_BUSY) begin
      cnt_r    <= cnt_r + CNT_W'(1);
      acc_r    <= acc_step_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
    end else begin
      cnt_r    <= cnt_r;
    end
  end

endmodule
